// File: rtl/alu_seq_core.sv
// alu_seq_core: single-request ALU with a valid/ready front end.
// Logic and add/sub ops finish in one cycle. MUL is a shift-add loop that
// handles one multiplier bit per cycle, LSB first. Completion is a one-cycle
// operation_done pulse, and result/carry/error hold until the next completion.
module alu_seq_core #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    input  logic [OP_WIDTH-1:0] operator,
    input  logic                op_valid,
    output logic                op_ready,
    output logic                operation_done,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                error,
    output logic [1:0]          fsm_state
);

    // Handshake: a request is taken on a rising edge where op_valid && op_ready.
    // op_ready is high only in IDLE. A requester that sees op_ready low keeps
    // op_valid and its operands steady. Nothing is queued, and a refused request
    // is not an error. Operands and opcode are captured on the accept edge, so
    // later changes on the inputs have no effect on the operation in flight.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(7);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // multiplier, shifted right each step
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               error_q, error_d;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_err;
    logic [WIDTH-1:0]   partial;

    // Single-cycle ALU on the live inputs, used only on an accept edge.
    always_comb begin
        sum_ext   = {1'b0, operand_a} + {1'b0, operand_b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (operator)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = operand_a - operand_b;
                alu_carry = (operand_a < operand_b);
            end
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_MUL:  alu_res = '0;  // produced by the shift-add loop instead
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            default: alu_err = 1'b1;
        endcase
    end

    // Next-state and datapath updates. Defaults hold every register.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        error_d  = error_q;
        partial  = mplier_q[0] ? mcand_q : '0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (operator == OP_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = operand_a;
                        mplier_d = operand_b;
                        acc_d    = '0;
                        cnt_d    = CNT_FULL;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        error_d  = alu_err;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                // The last multiplier bit is folded straight into result.
                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_DONE;
                    result_d = acc_q + partial;
                    carry_d  = 1'b0;
                    error_d  = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers. Reset drops any in-flight operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            error_q  <= error_d;
        end
    end

    assign op_ready       = (state_q == ST_IDLE);
    assign operation_done = (state_q == ST_DONE);
    assign result         = result_q;
    assign carry          = carry_q;
    assign error          = error_q;
    assign fsm_state      = state_q;

endmodule
